// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source register-file writeback arbiter with registered write port
// Define WB_RR_EN for round-robin contention resolution; default build gives s0 fixed priority.
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    input  logic [4:0]      s0_rd,
    input  logic [XLEN-1:0] s0_data,
    output logic            s0_ready,
    input  logic            s1_valid,
    input  logic [4:0]      s1_rd,
    input  logic [XLEN-1:0] s1_data,
    output logic            s1_ready,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] write_data,
    output logic [15:0]     conflict_cnt
);

    logic            last_grant_q, last_grant_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [15:0]     conflict_cnt_q, conflict_cnt_d;

    logic            contention;
    logic            prefer_s0;
    logic            grant0;
    logic            grant1;

    assign contention = s0_valid & s1_valid;

`ifdef WB_RR_EN
    // s0 wins a tie only when s1 took the previous grant
    assign prefer_s0 = last_grant_q;
`else
    assign prefer_s0 = 1'b1;
`endif

    // Readies are held low during reset so nothing can transfer into a clearing pipeline
    assign grant0 = ~rst & s0_valid & (~s1_valid | prefer_s0);
    assign grant1 = ~rst & s1_valid & ~grant0;

    assign s0_ready = grant0;
    assign s1_ready = grant1;

    always_comb begin
        reg_write_d    = 1'b0;
        rd_d           = rd_q;
        write_data_d   = write_data_q;
        last_grant_d   = last_grant_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant0) begin
            reg_write_d  = |s0_rd;
            rd_d         = s0_rd;
            write_data_d = s0_data;
            last_grant_d = 1'b0;
        end else if (grant1) begin
            reg_write_d  = |s1_rd;
            rd_d         = s1_rd;
            write_data_d = s1_data;
            last_grant_d = 1'b1;
        end

        if (contention && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q    <= 1'b0;
            rd_q           <= 5'd0;
            write_data_q   <= '0;
            last_grant_q   <= 1'b1;
            conflict_cnt_q <= 16'd0;
        end else begin
            reg_write_q    <= reg_write_d;
            rd_q           <= rd_d;
            write_data_q   <= write_data_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign reg_write    = reg_write_q;
    assign rd           = rd_q;
    assign write_data   = write_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
